// File: rtl/fft_fp_pkg.sv
// Shared FFT floating-point types: complex FP32 pairs, IEEE exception flags
// and the latency helper for the pipelined complex multiplier.
package fft_fp_pkg;

  localparam int FP_W = 32;

  typedef struct packed {
    logic [FP_W-1:0] re;
    logic [FP_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inv;
  } fp_flags_t;

  function automatic int cmul_lat(input int l_mul, input int l_add);
    return l_mul + l_add;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, searching from last granted + 1.
// The pointer only moves when the caller reports that the grant was taken.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0]                  req,
  input  logic                          advance,
  output logic [N-1:0]                  grant,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_id
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;

  // Walk from the farthest offset back to the pointer so the nearest requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant                         = '0;
        grant[(int'(ptr) + i) % N]    = 1'b1;
        grant_id                      = IW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
    end
  end

endmodule

// File: rtl/cmul_rr_sched.sv
// Shares one pipelined complex multiplier between N_REQ requesters: round-robin
// issue, a tag pipe that tracks the multiplier latency, response routing and sticky flags.
module cmul_rr_sched
  import fft_fp_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = 3,
  parameter int L_MUL = 2,
  parameter int L_ADD = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*64-1:0]    req_a,
  input  logic [N_REQ*64-1:0]    req_b,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   m_valid_in,
  output cplx_t                  m_a,
  output cplx_t                  m_b,
  input  logic                   m_valid_out,
  input  cplx_t                  m_p,
  input  logic                   m_ovf,
  input  logic                   m_unf,
  input  logic                   m_inv,
  output logic [N_REQ-1:0]       rsp_valid,
  output cplx_t                  rsp_p,
  output logic [TAG_W-1:0]       rsp_tag,
  output fp_flags_t              rsp_flags,
  input  logic                   flag_clr,
  output logic [N_REQ-1:0]       sticky_ovf,
  output logic [N_REQ-1:0]       sticky_unf,
  output logic [N_REQ-1:0]       sticky_inv,
  output logic                   sync_err,
  output logic                   idle
);

  localparam int LAT = cmul_lat(L_MUL, L_ADD);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic             vld;
    logic [IDW-1:0]   id;
    logic [TAG_W-1:0] tag;
  } tag_ent_t;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   iss_id;
  logic [TAG_W-1:0] iss_tag;
  tag_ent_t         pipe [LAT];
  tag_ent_t         tail;
  fp_flags_t        m_flags;
  logic             rsp_fire;
  logic [N_REQ-1:0] rsp_hit;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid & {N_REQ{i_en}}),
    .advance  (|grant),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_in <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      iss_id     <= '0;
      iss_tag    <= '0;
    end else begin
      m_valid_in <= |grant;
      if (|grant) begin
        m_a     <= req_a[int'(grant_id)*64 +: 64];
        m_b     <= req_b[int'(grant_id)*64 +: 64];
        iss_id  <= grant_id;
        iss_tag <= req_tag[int'(grant_id)*TAG_W +: TAG_W];
      end
    end
  end

  // Tag pipe runs in lockstep with the multiplier; its tail lines up with m_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: m_valid_in, id: iss_id, tag: iss_tag};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail     = pipe[LAT-1];
  assign m_flags  = '{ovf: m_ovf, unf: m_unf, inv: m_inv};
  assign rsp_fire = m_valid_out & tail.vld;
  assign rsp_hit  = rsp_fire ? (N_REQ'(1) << tail.id) : '0;

  // A new flag in the same cycle as flag_clr survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_p      <= '0;
      rsp_tag    <= '0;
      rsp_flags  <= '0;
      sticky_ovf <= '0;
      sticky_unf <= '0;
      sticky_inv <= '0;
      sync_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_hit;
      if (rsp_fire) begin
        rsp_p     <= m_p;
        rsp_tag   <= tail.tag;
        rsp_flags <= m_flags;
      end
      sticky_ovf <= (flag_clr ? '0 : sticky_ovf) | (rsp_hit & {N_REQ{m_flags.ovf}});
      sticky_unf <= (flag_clr ? '0 : sticky_unf) | (rsp_hit & {N_REQ{m_flags.unf}});
      sticky_inv <= (flag_clr ? '0 : sticky_inv) | (rsp_hit & {N_REQ{m_flags.inv}});
      sync_err   <= (sync_err & ~flag_clr) | (m_valid_out != tail.vld);
    end
  end

  always_comb begin
    idle = ~m_valid_in & ~(|rsp_valid);
    for (int i = 0; i < LAT; i++) idle = idle & ~pipe[i].vld;
  end

endmodule
